// File: rtl/hc_control_sequencer_pkg.sv
// Shared types, CSR map, control codes and completion-record layout for the
// host-controlled sequencer.
package hc_pkg;

   localparam int HC_BUFFER_SIZE = 4;
   localparam int CL_ADDR_W      = 42;

   typedef logic [CL_ADDR_W-1:0] t_ccip_clAddr;
   typedef logic [511:0]         t_buffer_data;
   typedef logic [63:0]          t_hc_address;

   typedef struct packed {
      t_hc_address address;
      logic [31:0] size;
   } t_hc_buffer;

   // MMIO header address counts 32-bit words.
   typedef struct packed {
      logic [15:0] address;
   } t_ccip_c0_ReqMmioHdr;

   typedef struct packed {
      logic                mmioWrValid;
      t_ccip_c0_ReqMmioHdr hdr;
      logic [63:0]         data;
   } t_if_ccip_c0_Rx;

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_IDLE   = 3'd1,
      S_RUN    = 3'd2,
      S_DSM_WR = 3'd3,
      S_DONE   = 3'd4
   } t_hc_seq_state;

   localparam logic [31:0] HC_CONTROL_ASSERT_RST   = 32'd0;
   localparam logic [31:0] HC_CONTROL_DEASSERT_RST = 32'd1;
   localparam logic [31:0] HC_CONTROL_START        = 32'd3;
   localparam logic [31:0] HC_CONTROL_STOP         = 32'd7;

   localparam logic [17:0] CSR_MMIO_LIMIT   = 18'h400;
   localparam logic [17:0] CSR_DSM_BASE     = 18'h110;
   localparam logic [17:0] CSR_CONTROL      = 18'h118;
   localparam logic [17:0] CSR_BUF_BASE     = 18'h120;
   localparam logic [17:0] CSR_BUF_STRIDE   = 18'h010;
   localparam logic [17:0] CSR_BUF_SIZE_OFS = 18'h008;

   localparam int DSM_DONE_BIT    = 0;
   localparam int DSM_STOPPED_BIT = 1;
   localparam int DSM_COUNT_LSB   = 64;

   function automatic logic [17:0] csr_buf_addr(input int idx, input logic size_sel);
      return CSR_BUF_BASE + CSR_BUF_STRIDE * 18'(idx) + (size_sel ? CSR_BUF_SIZE_OFS : 18'h0);
   endfunction

endpackage

// File: rtl/hc_control_sequencer_if.sv
// Completion-record write handshake toward the DSM writer.
interface hc_control_sequencer_if;
   import hc_pkg::*;

   logic         dsm_wr_valid;
   t_ccip_clAddr dsm_wr_addr;
   t_buffer_data dsm_wr_data;
   logic         dsm_wr_ack;

   modport master (output dsm_wr_valid, output dsm_wr_addr, output dsm_wr_data, input dsm_wr_ack);
   modport slave  (input dsm_wr_valid, input dsm_wr_addr, input dsm_wr_data, output dsm_wr_ack);
endinterface

// File: rtl/hc_control_sequencer_csr_decode.sv
// Combinational MMIO write decode: descriptor index/field, control and DSM-base strobes.
module hc_csr_decode
   import hc_pkg::*;
#(
   parameter int NUM_BUFFERS = HC_BUFFER_SIZE,
   parameter int IDX_W       = 2
) (
   input  logic             wr_valid,
   input  logic [15:0]      wr_addr,
   output logic [IDX_W-1:0] buf_idx,
   output logic             buf_sel_size,
   output logic             buf_wr,
   output logic             ctl_wr,
   output logic             dsm_base_wr
);
   logic [17:0] byte_addr;
   logic        in_range;

   always_comb begin
      byte_addr    = {wr_addr, 2'b00};
      in_range     = wr_valid && (byte_addr < CSR_MMIO_LIMIT);
      ctl_wr       = in_range && (byte_addr == CSR_CONTROL);
      dsm_base_wr  = in_range && (byte_addr == CSR_DSM_BASE);
      buf_idx      = '0;
      buf_sel_size = 1'b0;
      buf_wr       = 1'b0;
      // Only exact descriptor slots below NUM_BUFFERS decode; anything else is dropped.
      for (int i = 0; i < NUM_BUFFERS; i++) begin
         if (in_range && (byte_addr == csr_buf_addr(i, 1'b0))) begin
            buf_idx = IDX_W'(i);
            buf_wr  = 1'b1;
         end
         if (in_range && (byte_addr == csr_buf_addr(i, 1'b1))) begin
            buf_idx      = IDX_W'(i);
            buf_sel_size = 1'b1;
            buf_wr       = 1'b1;
         end
      end
   end
endmodule

// File: rtl/hc_control_sequencer.sv
// Host-controlled run sequencer: holds descriptors, releases user reset, times the
// run and posts a completion record to the DSM.
module hc_control_sequencer
   import hc_pkg::*;
#(
   parameter int NUM_BUFFERS     = HC_BUFFER_SIZE,
   parameter int DSM_DONE_OFFSET = 0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  t_if_ccip_c0_Rx         mmio_rx,
   output t_hc_buffer             buffer_table [NUM_BUFFERS],
   output t_hc_address            dsm_base,
   output logic                   user_rst_n,
   output logic                   user_start,
   input  logic                   user_done,
   hc_control_sequencer_if.master dsm_wr,
   output t_hc_seq_state          state
);
   localparam int IDX_W = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;

   logic [IDX_W-1:0] buf_idx;
   logic             buf_sel_size, buf_wr, ctl_wr, dsm_base_wr;
   logic [31:0]      ctl_code;
   logic             cmd_assert, cmd_deassert, cmd_start, cmd_stop, cfg_open;

   t_hc_seq_state state_reg, state_next;
   t_hc_address   dsm_base_reg;
   t_hc_buffer    table_reg [NUM_BUFFERS];
   logic [63:0]   cycle_count_reg;
   logic          stopped_reg, start_reg;

   hc_csr_decode #(.NUM_BUFFERS(NUM_BUFFERS), .IDX_W(IDX_W)) u_decode (
      .wr_valid     (mmio_rx.mmioWrValid),
      .wr_addr      (mmio_rx.hdr.address),
      .buf_idx      (buf_idx),
      .buf_sel_size (buf_sel_size),
      .buf_wr       (buf_wr),
      .ctl_wr       (ctl_wr),
      .dsm_base_wr  (dsm_base_wr)
   );

   assign ctl_code     = mmio_rx.data[31:0];
   assign cmd_assert   = ctl_wr && (ctl_code == HC_CONTROL_ASSERT_RST);
   assign cmd_deassert = ctl_wr && (ctl_code == HC_CONTROL_DEASSERT_RST);
   assign cmd_start    = ctl_wr && (ctl_code == HC_CONTROL_START);
   assign cmd_stop     = ctl_wr && (ctl_code == HC_CONTROL_STOP);
   // Configuration is frozen while the user logic may be reading it.
   assign cfg_open     = (state_reg != S_RUN) && (state_reg != S_DSM_WR);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= S_RESET;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_RESET:  if (cmd_deassert) state_next = S_IDLE;
         S_IDLE:   if (cmd_start) state_next = S_RUN;
         S_RUN:    if (user_done || cmd_stop) state_next = S_DSM_WR;
         S_DSM_WR: if (dsm_wr.dsm_wr_ack) state_next = S_DONE;
         S_DONE:   state_next = S_DONE;
         default:  state_next = S_RESET;
      endcase
      // Reset request wins over everything, including an ack in flight.
      if (cmd_assert) state_next = S_RESET;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dsm_base_reg    <= '0;
         for (int i = 0; i < NUM_BUFFERS; i++) table_reg[i] <= '0;
         cycle_count_reg <= '0;
         stopped_reg     <= 1'b0;
         start_reg       <= 1'b0;
      end else begin
         start_reg <= (state_reg == S_IDLE) && (state_next == S_RUN);
         if (dsm_base_wr && cfg_open) dsm_base_reg <= mmio_rx.data;
         if (buf_wr && cfg_open) begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
               if (buf_idx == IDX_W'(i)) begin
                  if (buf_sel_size) table_reg[i].size    <= mmio_rx.data[31:0];
                  else              table_reg[i].address <= mmio_rx.data;
               end
            end
         end
         if ((state_reg != S_RUN) && (state_next == S_RUN)) begin
            cycle_count_reg <= '0;
            stopped_reg     <= 1'b0;
         end else if (state_reg == S_RUN) begin
            if (cycle_count_reg != '1) cycle_count_reg <= cycle_count_reg + 64'd1;
            if (cmd_stop) stopped_reg <= 1'b1;
         end
      end
   end

   always_comb begin
      state               = state_reg;
      user_rst_n          = (state_reg != S_RESET);
      user_start          = start_reg;
      dsm_base            = dsm_base_reg;
      buffer_table        = table_reg;
      dsm_wr.dsm_wr_valid = (state_reg == S_DSM_WR);
      dsm_wr.dsm_wr_addr  = '0;
      dsm_wr.dsm_wr_data  = '0;
      if (state_reg == S_DSM_WR) begin
         dsm_wr.dsm_wr_addr = dsm_base_reg[CL_ADDR_W+5:6] + t_ccip_clAddr'(DSM_DONE_OFFSET);
         dsm_wr.dsm_wr_data[DSM_COUNT_LSB +: 64] = cycle_count_reg;
         dsm_wr.dsm_wr_data[DSM_STOPPED_BIT]     = stopped_reg;
         dsm_wr.dsm_wr_data[DSM_DONE_BIT]        = 1'b1;
      end
   end
endmodule
